// File: rtl/pipe_group_reg.sv
// pipe_group_reg: issue-group pipeline register with skid buffer, age-ordered flush and stall counter
module pipe_group_reg #(
  parameter int LANES = 2,
  parameter int W = 128,
  parameter int CLEAR_DATA = 1,
  parameter int CNT_W = 16,
  localparam int FW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LANES-1:0]   in_valid,
  input  logic [LANES*W-1:0] in_data,
  output logic               in_ready,
  output logic [LANES-1:0]   out_valid,
  output logic [LANES*W-1:0] out_data,
  input  logic               out_ready,
  input  logic               flush,
  input  logic [FW-1:0]      flush_from,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   stall_cycles
);
  logic [LANES-1:0] valid_m, valid_s, valid_m_n, valid_s_n, kill;
  logic [LANES*W-1:0] data_m, data_s, data_m_n, data_s_n;
  logic full_m, full_s, acc, fire;
  assign full_m = |valid_m;
  assign full_s = |valid_s;
  assign out_valid = valid_m & ~kill;
  assign out_data = data_m;
  assign in_ready = ~full_s;
  assign acc = in_ready & |in_valid & ~flush;
  assign fire = |out_valid & out_ready;
  // lanes at or above flush_from in the oldest group are killed
  always_comb begin
    kill = '0;
    for (int i = 0; i < LANES; i++) kill[i] = flush && (i >= int'(flush_from));
  end
  // next main/skid contents; the skid only fills when main holds and does not drain
  always_comb begin
    valid_m_n = valid_m;
    data_m_n = data_m;
    valid_s_n = valid_s;
    data_s_n = data_s;
    if (flush) begin
      valid_s_n = '0;
      valid_m_n = fire ? '0 : valid_m & ~kill;
      if (CLEAR_DATA != 0) begin
        data_s_n = '0;
        for (int i = 0; i < LANES; i++) if (fire || kill[i]) data_m_n[i*W +: W] = '0;
      end
    end else if (full_s) begin
      if (fire) begin
        valid_m_n = valid_s;
        data_m_n = data_s;
        valid_s_n = '0;
        if (CLEAR_DATA != 0) data_s_n = '0;
      end
    end else if (acc && (!full_m || fire)) begin
      valid_m_n = in_valid;
      data_m_n = in_data;
    end else if (acc) begin
      valid_s_n = in_valid;
      data_s_n = in_data;
    end else if (fire) begin
      valid_m_n = '0;
      if (CLEAR_DATA != 0) data_m_n = '0;
    end
  end
  // group storage; reset always zeroes payload
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_m <= '0;
      valid_s <= '0;
      data_m <= '0;
      data_s <= '0;
    end else begin
      valid_m <= valid_m_n;
      valid_s <= valid_s_n;
      data_m <= data_m_n;
      data_s <= data_s_n;
    end
  end
  // saturating count of cycles where a valid group is backpressured
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cycles <= '0;
    else if (cnt_clr) stall_cycles <= '0;
    else if (|out_valid && !out_ready && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
  end
endmodule

// File: tb/tb_pipe_group_reg.sv
// tb_pipe_group_reg: directed-vector bench for pipe_group_reg (2 lanes, 8-bit payload, 4-bit counter)
module tb_pipe_group_reg;
  localparam int LANES = 2;
  localparam int W = 8;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [LANES-1:0] in_valid = '0;
  logic [LANES*W-1:0] in_data = '0;
  logic in_ready;
  logic [LANES-1:0] out_valid;
  logic [LANES*W-1:0] out_data;
  logic out_ready = 1'b0;
  logic flush = 1'b0;
  logic [0:0] flush_from = '0;
  logic cnt_clr = 1'b0;
  logic [CNT_W-1:0] stall_cycles;
  int vectors = 0;
  int errs = 0;

  pipe_group_reg #(.LANES(LANES), .W(W), .CLEAR_DATA(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .flush(flush),
    .flush_from(flush_from), .cnt_clr(cnt_clr), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] grp(input int k);
    return {8'(k * 16 + 2), 8'(k * 16 + 1)};
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    chk("rst_ov", out_valid, 0);
    chk("rst_od", out_data, 0);
    chk("rst_ir", in_ready, 1);
    chk("rst_cnt", stall_cycles, 0);
    #10 rst = 1'b1;
    step();
    chk("post_rst_ov", out_valid, 0);
    // streaming: each group appears one edge after it is offered
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 2'b11;
      in_data = grp(k);
      step();
      chk("stream_ov", out_valid, 2'b11);
      chk("stream_od", out_data, grp(k));
      chk("stream_ir", in_ready, 1);
    end
    in_valid = '0;
    step();
    chk("stream_drain_ov", out_valid, 0);
    chk("stream_drain_od", out_data, 0);
    chk("stream_cnt", stall_cycles, 0);
    // backpressure: A to main, B to skid, C held off
    out_ready = 1'b0;
    in_valid = 2'b11;
    in_data = grp(10);
    step();
    chk("bp_a_od", out_data, grp(10));
    chk("bp_a_ir", in_ready, 1);
    chk("bp_a_cnt", stall_cycles, 0);
    in_data = grp(11);
    step();
    chk("bp_b_ir", in_ready, 0);
    chk("bp_b_od", out_data, grp(10));
    chk("bp_b_cnt", stall_cycles, 1);
    in_data = grp(12);
    step();
    chk("bp_c_ir", in_ready, 0);
    chk("bp_c_cnt", stall_cycles, 2);
    out_ready = 1'b1;
    #1;
    chk("bp_pre_od", out_data, grp(10));
    step();
    chk("bp_b_out", out_data, grp(11));
    chk("bp_b_ir2", in_ready, 1);
    step();
    chk("bp_c_out", out_data, grp(12));
    chk("bp_c_ov", out_valid, 2'b11);
    in_valid = '0;
    step();
    chk("bp_empty_ov", out_valid, 0);
    chk("bp_cnt_final", stall_cycles, 2);
    // partial flush from SKID: only lane 0 of main leaves, skid is discarded
    out_ready = 1'b0;
    in_valid = 2'b11;
    in_data = grp(13);
    step();
    in_data = grp(14);
    step();
    chk("pf_skid_ir", in_ready, 0);
    in_valid = '0;
    flush = 1'b1;
    flush_from = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("pf_ov", out_valid, 2'b01);
    chk("pf_od", out_data, grp(13));
    step();
    flush = 1'b0;
    chk("pf_next_ov", out_valid, 0);
    chk("pf_next_od", out_data, 0);
    chk("pf_next_ir", in_ready, 1);
    step();
    chk("pf_no_skid_ov", out_valid, 0);
    // full flush with a concurrent input group
    out_ready = 1'b0;
    in_valid = 2'b11;
    in_data = grp(5);
    step();
    chk("ff_full_ov", out_valid, 2'b11);
    flush = 1'b1;
    flush_from = 1'b0;
    in_data = grp(6);
    #1;
    chk("ff_ov", out_valid, 0);
    step();
    flush = 1'b0;
    in_valid = '0;
    out_ready = 1'b1;
    #1;
    chk("ff_next_ov", out_valid, 0);
    chk("ff_next_od", out_data, 0);
    step();
    chk("ff_drop_ov", out_valid, 0);
    // counter saturation and clear priority
    cnt_clr = 1'b1;
    step();
    chk("cnt_clr0", stall_cycles, 0);
    cnt_clr = 1'b0;
    out_ready = 1'b0;
    in_valid = 2'b11;
    in_data = grp(7);
    step();
    in_valid = '0;
    for (int i = 0; i < 20; i++) step();
    chk("cnt_sat", stall_cycles, 15);
    chk("cnt_sat_ov", out_valid, 2'b11);
    cnt_clr = 1'b1;
    step();
    chk("cnt_clr_pri", stall_cycles, 0);
    cnt_clr = 1'b0;
    step();
    chk("cnt_restart", stall_cycles, 1);
    // asynchronous reset in SKID state, between edges
    in_valid = 2'b11;
    in_data = grp(8);
    step();
    in_valid = '0;
    chk("ar_skid_ir", in_ready, 0);
    #2 rst = 1'b0;
    #1;
    chk("ar_ov", out_valid, 0);
    chk("ar_ir", in_ready, 1);
    chk("ar_cnt", stall_cycles, 0);
    chk("ar_od", out_data, 0);
    #2 rst = 1'b1;
    in_valid = 2'b11;
    in_data = grp(9);
    out_ready = 1'b1;
    #1;
    chk("ar_rel_ov", out_valid, 0);
    step();
    chk("ar_first_ov", out_valid, 2'b11);
    chk("ar_first_od", out_data, grp(9));
    in_valid = '0;
    step();
    chk("ar_end_ov", out_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/pipe_group_reg.md
Name: pipe_group_reg

Overview:
- Parametrised successor to the fixed two-lane EX/MEM register: one in-order issue group of LANES lanes, each carrying a W-bit payload, crosses a pipeline boundary under a valid/ready handshake.
- Lane 0 is the oldest lane of a group.
- Adds three things the old register lacks: a one-group skid buffer (in_ready is registered), age-ordered partial flush, and a saturating stall counter.
- Sits between any two pipeline stages (EX/MEM first).

Parameters:
- LANES, 2: issue width (number of lanes per group), legal range 1..8.
- W, 128: payload bits per lane (packed bundle: control, exception, pc, inst, result, ...).
- CLEAR_DATA, 1: when 1, flushed or reset lanes also zero their payload; when 0, only their valid bit clears.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  LANES  per-lane valid of the incoming group.
- in_data  in  LANES*W  lane i occupies bits [i*W +: W].
- in_ready  out  1  group accepted on an edge when in_ready & |in_valid & ~flush.
- out_valid  out  LANES  per-lane valid of the held oldest group, masked by flush.
- out_data  out  LANES*W  payload of the held oldest group.
- out_ready  in  1  downstream accepts the whole group.
- flush  in  1  age-ordered kill request.
- flush_from  in  $clog2(LANES) (min 1)  first lane killed in the oldest group.
- cnt_clr  in  1  synchronous clear of stall_cycles.
- stall_cycles  out  CNT_W  saturating count of backpressured cycles.

Behaviour:
- Storage: main group (valid_m, data_m) and skid group (valid_s, data_s). The skid group is always younger than the main group.
- States, derived from the valid bits:
  - EMPTY: |valid_m = 0.
  - FULL: |valid_m = 1, |valid_s = 0.
  - SKID: both non-empty.
  - Invariant: |valid_s = 1 implies |valid_m = 1.
- kill[i] = flush & (i >= flush_from). flush_from >= LANES means no main lane is killed.
- Output signals:
  - out_valid[i] = valid_m[i] & ~kill[i].
  - out_data = data_m.
  - fire = |out_valid & out_ready.
- in_ready = ~SKID. It is a pure function of registered state with no combinational path from out_ready.
- acc = in_ready & |in_valid & ~flush. Lanes with in_valid = 0 inside an accepted group are bubbles and pass through as-is.
- Transitions with flush = 0:
  - EMPTY: acc -> main <= input, FULL.
  - FULL: fire & acc -> main <= input, stay FULL. fire & ~acc -> EMPTY. ~fire & acc -> skid <= input, SKID. Otherwise hold.
  - SKID: fire -> main <= skid, skid cleared, FULL. Otherwise hold. No accept is possible in SKID.
- Flush precedence: rst > flush > handshake.
  - Kills main lanes >= flush_from, clears the whole skid group, and drops the input group.
  - Surviving main lanes (i < flush_from) still transfer if fire. If fire, main is cleared.
  - Next state is FULL if surviving lanes remain un-fired; otherwise EMPTY.
  - flush_from = 0 clears everything, giving EMPTY next cycle.
- CLEAR_DATA = 1: every lane whose valid bit is cleared by flush, reset or being emptied has its data zeroed. Data of lanes that stay valid never changes while held.
- Latency:
  - Input to output: 1 cycle when EMPTY, or when FULL with fire on the accept edge.
  - Throughput: 1 group/cycle with out_ready held at 1.
- stall_cycles:
  - Increments when |out_valid & ~out_ready; saturates at all-ones.
  - cnt_clr has priority over increment and gives 0.
- Reset (rst = 0), applied asynchronously at any time including mid-transfer:
  - valid_m = valid_s = 0; data_m = data_s = 0 regardless of CLEAR_DATA.
  - out_valid = 0, out_data = 0, in_ready = 1, stall_cycles = 0.
  - After release: no spurious out_valid until an accept.

Test Plan:
- Streaming: LANES=2, out_ready=1, 4 groups with data 0x11/0x12, 0x21/0x22, ... offered back-to-back -> each appears exactly 1 cycle later, in order; in_ready stays 1; stall_cycles=0.
- Backpressure/skid: out_ready=0 while groups A, B are offered -> A in main, B in skid, in_ready=0 in the cycle after B; C held off by the source. Raise out_ready -> A, B, C emerge in order with none lost or duplicated; stall_cycles equals the number of out_ready=0 cycles with out_valid set.
- Partial flush: SKID state, flush=1, flush_from=1, out_ready=1 -> lane 0 of main transfers that cycle with out_valid=2'b01; next cycle EMPTY; skid contents never appear; CLEAR_DATA=1 gives data_m lane1 = 0.
- Full flush with concurrent input: FULL, flush=1, flush_from=0, in_valid=2'b11 -> out_valid=0 in that cycle; next state EMPTY; the input group is dropped (never output).
- Async reset mid-operation: SKID state, assert rst between edges -> out_valid=0, in_ready=1, stall_cycles=0 immediately without waiting for a clock edge; after release, the first accepted group emerges 1 cycle later.
- Counter saturation: CNT_W=4, out_valid set with out_ready=0 for 20 cycles -> stall_cycles=15 and holds; cnt_clr=1 together with a stall cycle -> 0.
